// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

    localparam int NUM_REQ_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_LOCK      = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner search: first requester strictly after rr_ptr, wrapping.
// Purely combinational; no backpressure of its own.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   win_idx,
    output logic               found
);
    logic [IDX_W:0] cand;

    // Walk from farthest to nearest so the nearest requester after rr_ptr wins.
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                win_idx = cand[IDX_W-1:0];
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding one UART transmitter (abort watchdog: UART_ARB_TIMEOUT_EN).
// Latency: byte on tx_valid one clk after its transfer; at least 2 clk overhead per byte.
// Backpressure: req_ready only in IDLE (winner) or LOCK (owner); held off while a frame is in flight.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 err_timeout
);
    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               last_q, last_d;

    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [IDX_W-1:0]   src_idx;
    logic               xfer;
    logic [7:0]         src_byte;
    logic               src_last;
    logic               tmo_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .win_idx (win_idx),
        .found   (win_found)
    );

    always_comb begin
        src_byte = 8'h00;
        src_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_idx == IDX_W'(i)) begin
                src_byte = req_data[8*i +: 8];
                src_last = req_last[i];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_timeout_q;

    // Counts every cycle a byte is outstanding; each new transfer restarts it.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_hit   = 1'b0;
        if (state_q == ST_SEND || state_q == ST_WAIT_DONE) begin
            tmo_hit   = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        if (xfer) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            err_timeout_q <= tmo_hit;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    logic unused_tmo_cfg;

    assign tmo_hit        = 1'b0;
    assign err_timeout    = 1'b0;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        last_d     = last_q;
        req_ready  = '0;
        xfer       = 1'b0;
        src_idx    = win_idx;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    req_ready = NUM_REQ'(1) << win_idx;
                    xfer      = 1'b1;
                    grant_d   = NUM_REQ'(1) << win_idx;
                    owner_d   = win_idx;
                end
            end
            ST_SEND: begin
                if (!tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = owner_q;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                // Packet lock: only the owner may continue, however long it takes.
                req_ready = grant_q;
                src_idx   = owner_q;
                xfer      = req_valid[owner_q];
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (xfer) begin
            tx_data_d  = src_byte;
            last_d     = src_last;
            tx_valid_d = 1'b1;
            state_d    = ST_SEND;
        end

        if (tmo_hit) begin
            tx_valid_d = 1'b0;
            grant_d    = '0;
            rr_ptr_d   = owner_q;
            state_d    = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            last_q     <= last_d;
        end
    end

    assign grant    = grant_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte queues per requester, a transmitter stub, transfer logging.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic              busy;
    logic              err_timeout;

    uart_tx_arbiter #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [8:0]      src_mem [NREQ][16];
    int              src_wr [NREQ];
    int              src_rd [NREQ];
    logic            src_hold [NREQ];
    int              log_idx [64];
    logic [7:0]      log_dat [64];
    int              n_xfer = 0;
    logic [7:0]      txd_log [64];
    logic [NREQ-1:0] txg_log [64];
    int              n_tx = 0;
    int              rdy_multi = 0, rdy_bad = 0, lat_bad = 0, grant_bad = 0;
    int              rdy2_at = -1;
    logic            stub_hold = 1'b0;

    logic            mon_pend = 1'b0;
    logic [7:0]      mon_byte = 8'h00;
    logic            prev_tv = 1'b0, prev_busy = 1'b0;
    logic [NREQ-1:0] prev_grant = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push(input int i, input logic last, input logic [7:0] d);
        src_mem[i][src_wr[i]] = {last, d};
        src_wr[i]++;
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < NREQ; i++) begin
            if (src_rd[i] != src_wr[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_quiet(input string tag);
        int n;
        int quiet;
        n = 0;
        quiet = 0;
        while (quiet < 2 && n < 400) begin
            step();
            #5;
            n++;
            quiet = (!busy && queues_empty()) ? quiet + 1 : 0;
        end
        chk(tag, (quiet >= 2), 1);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
            src_hold[i] = 1'b0;
        end
        n_xfer = 0;
        n_tx = 0;
        rdy2_at = -1;
        step();
        step();
        rst = 1'b1;
    endtask

    // Transmitter stub: frame starts 3 clk after the offer and lasts 10 clk.
    initial begin
        forever begin
            @(negedge clk);
            if (!stub_hold && tx_valid) begin
                repeat (3) @(negedge clk);
                tx_ready = 1'b0;
                repeat (10) @(negedge clk);
                tx_ready = 1'b1;
            end
        end
    end

    // Requester sources plus per-cycle protocol monitor.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            for (int i = 0; i < NREQ; i++) begin
                if (src_rd[i] != src_wr[i] && !src_hold[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = src_mem[i][src_rd[i]][7:0];
                    req_last[i]        = src_mem[i][src_rd[i]][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
            #1;
            if (rst) begin
                if (mon_pend && !(tx_valid && tx_data == mon_byte)) lat_bad++;
                mon_pend = 1'b0;
                if ($countones(req_ready) > 1) rdy_multi++;
                if (tx_valid && req_ready != '0) rdy_bad++;
                if (busy && req_ready != '0 && req_ready != grant) rdy_bad++;
                if (busy && prev_busy && grant != prev_grant) grant_bad++;
                if (tx_valid && !prev_tv && n_tx < 64) begin
                    txd_log[n_tx] = tx_data;
                    txg_log[n_tx] = grant;
                    n_tx++;
                end
                if (req_ready[2] && rdy2_at < 0) rdy2_at = n_xfer;
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && req_ready[i] && n_xfer < 64) begin
                        log_idx[n_xfer] = i;
                        log_dat[n_xfer] = req_data[8*i +: 8];
                        n_xfer++;
                        src_rd[i]++;
                        mon_pend = 1'b1;
                        mon_byte = req_data[8*i +: 8];
                    end
                end
            end else begin
                mon_pend = 1'b0;
            end
            prev_tv    = tx_valid;
            prev_busy  = busy;
            prev_grant = grant;
        end
    end

    initial begin
        int n;
        int viol;
        int pulses;
        int pulse_at;
        for (int i = 0; i < NREQ; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
            src_hold[i] = 1'b0;
        end

        // Reset state
        step();
        step();
        #5;
        chk("rst_grant", grant, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_ready", req_ready, 0);
        step();
        rst = 1'b1;

        // Single byte, then immediate re-grant of the same requester
        push(0, 1'b1, 8'hA5);
        n = 0;
        do begin step(); #5; n++; end while (tx_ready && n < 100);
        chk("sb_reach_drop", !tx_ready, 1);
        chk("sb_send_valid", tx_valid, 1);
        chk("sb_send_data", tx_data, 8'hA5);
        step();
        #5;
        chk("sb_wait_grant", grant, 4'b0001);
        chk("sb_wait_valid", tx_valid, 0);
        chk("sb_wait_busy", busy, 1);
        chk("sb_wait_ready", req_ready, 0);
        wait_quiet("sb_done");
        chk("sb_nxfer", n_xfer, 1);
        chk("sb_idx", log_idx[0], 0);
        chk("sb_dat", log_dat[0], 8'hA5);
        chk("sb_ntx", n_tx, 1);
        chk("sb_txd", txd_log[0], 8'hA5);
        chk("sb_txg", txg_log[0], 4'b0001);
        chk("sb_end_grant", grant, 0);
        push(0, 1'b1, 8'h5A);
        wait_quiet("regrant_done");
        chk("regrant_idx", log_idx[1], 0);
        chk("regrant_dat", log_dat[1], 8'h5A);

        // Round robin across all four requesters
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            push(i, 1'b1, 8'h10 + 8'(i));
            push(i, 1'b1, 8'h20 + 8'(i));
        end
        wait_quiet("rr_done");
        chk("rr_nxfer", n_xfer, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr_idx%0d", k), log_idx[k], k % 4);
            chk($sformatf("rr_dat%0d", k), log_dat[k], (k < 4 ? 8'h10 : 8'h20) + 8'(k % 4));
        end
        chk("rr_txg4", txg_log[4], 4'b0001);

        // Packet lock: req1's three bytes before any req2 byte
        do_reset();
        push(1, 1'b0, 8'h11);
        push(1, 1'b0, 8'h22);
        push(1, 1'b1, 8'h33);
        push(2, 1'b1, 8'h44);
        wait_quiet("lock_done");
        chk("lock_nxfer", n_xfer, 4);
        chk("lock_idx0", log_idx[0], 1);
        chk("lock_dat1", log_dat[1], 8'h22);
        chk("lock_idx2", log_idx[2], 1);
        chk("lock_dat2", log_dat[2], 8'h33);
        chk("lock_idx3", log_idx[3], 2);
        chk("lock_dat3", log_dat[3], 8'h44);
        chk("lock_rdy2_after", rdy2_at, 3);

        // LOCK stall: req3 withholds its second byte while req0 waits
        do_reset();
        push(3, 1'b0, 8'hC1);
        n = 0;
        do begin step(); #5; n++; end while (n_xfer < 1 && n < 50);
        chk("stall_first", n_xfer, 1);
        push(0, 1'b1, 8'hD0);
        n = 0;
        do begin step(); #5; n++; end
        while (!(busy && !tx_valid && tx_ready && req_ready == 4'b1000) && n < 100);
        chk("stall_lock_reached", (busy && !tx_valid && req_ready == 4'b1000), 1);
        viol = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            #5;
            if (grant != 4'b1000 || !busy || tx_valid || req_ready[0]) viol++;
        end
        chk("stall_hold", viol, 0);
        chk("stall_nxfer", n_xfer, 1);
        push(3, 1'b1, 8'hC2);
        wait_quiet("stall_done");
        chk("stall_idx1", log_idx[1], 3);
        chk("stall_dat1", log_dat[1], 8'hC2);
        chk("stall_idx2", log_idx[2], 0);
        chk("stall_dat2", log_dat[2], 8'hD0);

        // Reset mid-packet, in WAIT_DONE
        do_reset();
        push(2, 1'b0, 8'hE1);
        push(2, 1'b1, 8'hE2);
        n = 0;
        do begin step(); #5; n++; end while (tx_ready && n < 100);
        step();
        #5;
        chk("rm_in_wait", (busy && !tx_valid && !tx_ready), 1);
        push(0, 1'b1, 8'hF0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        #5;
        chk("rm_grant", grant, 0);
        chk("rm_tx_valid", tx_valid, 0);
        chk("rm_busy", busy, 0);
        wait_quiet("rm_done");
        chk("rm_nxfer", n_xfer, 3);
        chk("rm_idx1", log_idx[1], 0);
        chk("rm_dat1", log_dat[1], 8'hF0);
        chk("rm_idx2", log_idx[2], 2);
        chk("rm_dat2", log_dat[2], 8'hE2);

        // Transmitter never starts the frame
        do_reset();
        stub_hold = 1'b1;
        push(1, 1'b1, 8'h77);
        n = 0;
        do begin step(); #5; n++; end while (n_xfer < 1 && n < 50);
        chk("tmo_xfer", n_xfer, 1);
        pulses = 0;
        pulse_at = -1;
        for (int k = 0; k < 25; k++) begin
            step();
            #5;
            if (err_timeout) begin
                pulses++;
                if (pulse_at < 0) begin
                    pulse_at = k;
`ifdef UART_ARB_TIMEOUT_EN
                    chk("tmo_busy", busy, 0);
                    chk("tmo_tx_valid", tx_valid, 0);
                    chk("tmo_grant", grant, 0);
`endif
                end
            end
        end
`ifdef UART_ARB_TIMEOUT_EN
        chk("tmo_cycle", pulse_at, 20);
        chk("tmo_pulses", pulses, 1);
        stub_hold = 1'b0;
`else
        chk("notmo_pulses", pulses, 0);
        chk("notmo_busy", busy, 1);
        chk("notmo_tx_valid", tx_valid, 1);
        chk("notmo_tx_data", tx_data, 8'h77);
        stub_hold = 1'b0;
        wait_quiet("notmo_done");
`endif

        chk("mon_ready_onehot", rdy_multi, 0);
        chk("mon_ready_blocked", rdy_bad, 0);
        chk("mon_latency", lat_bad, 0);
        chk("mon_grant_stable", grant_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
